// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share a single combinational ALU.
// A grant picks one requester, its operands go through the ALU, and
// the result is captured in a one-deep output register. The output
// register can be refilled in the same cycle it is drained, so the
// block sustains one operation per cycle.

// CmbALU: purely combinational 32-bit ALU.
// Shift-type ops (SLL/SRL/SRA) and LUI operate on the y operand.
// Unknown op codes produce zero.
module CmbALU #(
  parameter int ALU_OP_BIT = 4
) (
  input  logic [ALU_OP_BIT-1:0] i_op,
  input  logic [31:0]           i_x,
  input  logic [31:0]           i_y,
  input  logic [4:0]            i_shamt,
  output logic [31:0]           o_res
);

  localparam logic [ALU_OP_BIT-1:0] OP_ADD  = ALU_OP_BIT'(0);
  localparam logic [ALU_OP_BIT-1:0] OP_SUB  = ALU_OP_BIT'(1);
  localparam logic [ALU_OP_BIT-1:0] OP_AND  = ALU_OP_BIT'(2);
  localparam logic [ALU_OP_BIT-1:0] OP_OR   = ALU_OP_BIT'(3);
  localparam logic [ALU_OP_BIT-1:0] OP_XOR  = ALU_OP_BIT'(4);
  localparam logic [ALU_OP_BIT-1:0] OP_SLL  = ALU_OP_BIT'(5);
  localparam logic [ALU_OP_BIT-1:0] OP_SRL  = ALU_OP_BIT'(6);
  localparam logic [ALU_OP_BIT-1:0] OP_SRA  = ALU_OP_BIT'(7);
  localparam logic [ALU_OP_BIT-1:0] OP_SLT  = ALU_OP_BIT'(8);
  localparam logic [ALU_OP_BIT-1:0] OP_SLTU = ALU_OP_BIT'(9);
  localparam logic [ALU_OP_BIT-1:0] OP_LUI  = ALU_OP_BIT'(10);

  // Decode the op code and compute the result; unknown codes fall to zero.
  always_comb begin
    o_res = 32'h0;
    case (i_op)
      OP_ADD:  o_res = i_x + i_y;
      OP_SUB:  o_res = i_x - i_y;
      OP_AND:  o_res = i_x & i_y;
      OP_OR:   o_res = i_x | i_y;
      OP_XOR:  o_res = i_x ^ i_y;
      OP_SLL:  o_res = i_y << i_shamt;
      OP_SRL:  o_res = i_y >> i_shamt;
      OP_SRA:  o_res = $unsigned($signed(i_y) >>> i_shamt);
      OP_SLT:  o_res = {31'h0, ($signed(i_x) < $signed(i_y))};
      OP_SLTU: o_res = {31'h0, (i_x < i_y)};
      OP_LUI:  o_res = {i_y[15:0], 16'h0};
      default: o_res = 32'h0;
    endcase
  end

endmodule

// alu_arbiter: arbitration, operand mux and result register.
module alu_arbiter #(
  parameter int PRIO_MODE  = 0,
  parameter int ALU_OP_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ALU_OP_BIT-1:0] req0_op,
  input  logic [31:0]           req0_x,
  input  logic [31:0]           req0_y,
  input  logic [4:0]            req0_shamt,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ALU_OP_BIT-1:0] req1_op,
  input  logic [31:0]           req1_x,
  input  logic [31:0]           req1_y,
  input  logic [4:0]            req1_shamt,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [31:0]           res_data,
  output logic                  res_src,
  output logic                  busy
);

  logic                  r_ptr;
  logic                  r_resValid;
  logic [31:0]           r_resData;
  logic                  r_resSrc;

  logic                  w_canAccept;
  logic                  w_grant;
  logic                  w_req0Ready;
  logic                  w_req1Ready;
  logic                  w_accept;
  logic [ALU_OP_BIT-1:0] w_op;
  logic [31:0]           w_x;
  logic [31:0]           w_y;
  logic [4:0]            w_shamt;
  logic [31:0]           w_aluRes;

  // The result slot is free when empty or when it is being drained now.
  assign w_canAccept = !r_resValid || res_ready;

  // Grant uses only the request valids and the pointer, never any ready,
  // so no combinational loop forms through the consumer handshake.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = (PRIO_MODE != 0) ? 1'b0 : r_ptr;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  // Readies are held low during reset so nothing is accepted into a
  // register that is being cleared.
  assign w_req0Ready = !rst && w_canAccept && req0_valid && (w_grant == 1'b0);
  assign w_req1Ready = !rst && w_canAccept && req1_valid && (w_grant == 1'b1);
  assign w_accept    = w_req0Ready || w_req1Ready;

  // Steer the granted requester's operands into the shared ALU.
  always_comb begin
    w_op    = req0_op;
    w_x     = req0_x;
    w_y     = req0_y;
    w_shamt = req0_shamt;
    if (w_grant) begin
      w_op    = req1_op;
      w_x     = req1_x;
      w_y     = req1_y;
      w_shamt = req1_shamt;
    end
  end

  CmbALU #(
    .ALU_OP_BIT(ALU_OP_BIT)
  ) u_alu (
    .i_op    (w_op),
    .i_x     (w_x),
    .i_y     (w_y),
    .i_shamt (w_shamt),
    .o_res   (w_aluRes)
  );

  // Round-robin pointer: after a transfer the other port is preferred.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (w_accept) begin
      r_ptr <= ~w_grant;
    end
  end

  // Result register: load on accept (also while draining), clear on drain only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resValid <= 1'b0;
      r_resData  <= 32'h0;
      r_resSrc   <= 1'b0;
    end else if (w_accept) begin
      r_resValid <= 1'b1;
      r_resData  <= w_aluRes;
      r_resSrc   <= w_grant;
    end else if (res_ready) begin
      r_resValid <= 1'b0;
    end
  end

  assign req0_ready = w_req0Ready;
  assign req1_ready = w_req1Ready;
  assign res_valid  = r_resValid;
  assign res_data   = r_resData;
  assign res_src    = r_resSrc;
  assign busy       = r_resValid && !res_ready;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus a randomized run against a
// behavioural model of the arbiter. A second instance in fixed-priority
// mode is exercised with directed contention.
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_LUI  = 4'd10;

  logic        clk = 1'b0;
  logic        rst;

  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_x, req0_y, req1_x, req1_y;
  logic [4:0]  req0_shamt, req1_shamt;
  logic        res_valid, res_ready, res_src, busy;
  logic [31:0] res_data;

  logic        q0_valid, q1_valid, q0_ready, q1_ready;
  logic [3:0]  q0_op, q1_op;
  logic [31:0] q0_x, q0_y, q1_x, q1_y;
  logic [4:0]  q0_shamt, q1_shamt;
  logic        qRes_valid, qRes_ready, qRes_src, qBusy;
  logic [31:0] qRes_data;

  int checks = 0;
  int errors = 0;

  logic        mPtr, mResValid, mResSrc;
  logic [31:0] mResData;
  logic        hold0, hold1;
  logic [3:0]  s0Op, s1Op;
  logic [31:0] s0X, s0Y, s1X, s1Y;
  logic [4:0]  s0Sh, s1Sh;

  alu_arbiter #(.PRIO_MODE(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_x(req0_x), .req0_y(req0_y), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_x(req1_x), .req1_y(req1_y), .req1_shamt(req1_shamt),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_src(res_src), .busy(busy)
  );

  alu_arbiter #(.PRIO_MODE(1)) dutPrio (
    .clk(clk), .rst(rst),
    .req0_valid(q0_valid), .req0_ready(q0_ready), .req0_op(q0_op),
    .req0_x(q0_x), .req0_y(q0_y), .req0_shamt(q0_shamt),
    .req1_valid(q1_valid), .req1_ready(q1_ready), .req1_op(q1_op),
    .req1_x(q1_x), .req1_y(q1_y), .req1_shamt(q1_shamt),
    .res_valid(qRes_valid), .res_ready(qRes_ready), .res_data(qRes_data),
    .res_src(qRes_src), .busy(qBusy)
  );

  always #5 clk = ~clk;

  // Compare one observed value with its expected value and log a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  // Reference ALU written from the operation definitions.
  function automatic logic [31:0] aluRef(input logic [3:0] op, input logic [31:0] x,
                                         input logic [31:0] y, input logic [4:0] sh);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_SLL:  return 32'(64'(y) * (64'd1 << sh));
      OP_SRL:  return y / (32'd1 << sh);
      OP_SRA:  return y[31] ? ((y >> sh) | ~(32'hFFFF_FFFF >> sh)) : (y >> sh);
      OP_SLT:  return (sx < sy) ? 32'd1 : 32'd0;
      OP_SLTU: return (x < y) ? 32'd1 : 32'd0;
      OP_LUI:  return 32'(64'(y) * 64'd65536);
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelReset();
    mPtr = 1'b0; mResValid = 1'b0; mResSrc = 1'b0; mResData = 32'h0;
    hold0 = 1'b0; hold1 = 1'b0;
  endtask

  task automatic drive0(input logic v, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] sh);
    req0_valid = v; req0_op = op; req0_x = x; req0_y = y; req0_shamt = sh;
  endtask

  task automatic drive1(input logic v, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] sh);
    req1_valid = v; req1_op = op; req1_x = x; req1_y = y; req1_shamt = sh;
  endtask

  // One clock of the round-robin instance, checked against the model.
  // Called just after a falling edge with inputs already driven.
  task automatic stepCycle();
    logic canAcc, pick, e0, e1;
    logic [31:0] nextRes;
    #1;
    if (hold0) assert (req0_valid && req0_op == s0Op && req0_x == s0X && req0_y == s0Y && req0_shamt == s0Sh)
      else $error("[TB] requester 0 payload changed while stalled");
    if (hold1) assert (req1_valid && req1_op == s1Op && req1_x == s1X && req1_y == s1Y && req1_shamt == s1Sh)
      else $error("[TB] requester 1 payload changed while stalled");
    canAcc = !mResValid || res_ready;
    // preferred port wins if it is requesting, otherwise whichever one is
    if ((mPtr ? req1_valid : req0_valid)) pick = mPtr;
    else pick = req1_valid;
    e0 = canAcc && req0_valid && (pick == 1'b0);
    e1 = canAcc && req1_valid && (pick == 1'b1);
    nextRes = pick ? aluRef(req1_op, req1_x, req1_y, req1_shamt)
                   : aluRef(req0_op, req0_x, req0_y, req0_shamt);
    checkOutput("req0_ready", req0_ready, e0);
    checkOutput("req1_ready", req1_ready, e1);
    checkOutput("busy", busy, mResValid && !res_ready);
    hold0 = req0_valid && !e0;
    hold1 = req1_valid && !e1;
    s0Op = req0_op; s0X = req0_x; s0Y = req0_y; s0Sh = req0_shamt;
    s1Op = req1_op; s1X = req1_x; s1Y = req1_y; s1Sh = req1_shamt;
    @(posedge clk);
    if (e0 || e1) begin
      mResValid = 1'b1; mResData = nextRes; mResSrc = pick; mPtr = ~pick;
    end else if (res_ready) begin
      mResValid = 1'b0;
    end
    #1;
    checkOutput("res_valid", res_valid, mResValid);
    if (mResValid) begin
      checkOutput("res_data", res_data, mResData);
      checkOutput("res_src", res_src, mResSrc);
    end
    @(negedge clk);
  endtask

  // One clock of the fixed-priority instance with literal expectations.
  task automatic prioCycle(input logic e0, input logic e1, input logic [31:0] d, input logic s);
    #1;
    checkOutput("prio_req0_ready", q0_ready, e0);
    checkOutput("prio_req1_ready", q1_ready, e1);
    @(posedge clk);
    #1;
    checkOutput("prio_res_valid", qRes_valid, 1);
    checkOutput("prio_res_data", qRes_data, d);
    checkOutput("prio_res_src", qRes_src, s);
    @(negedge clk);
  endtask

  // Randomize requester payloads, keeping stalled requests unchanged.
  task automatic applyStimulus();
    if (!hold0) begin
      req0_valid = ($urandom_range(0, 99) < 65);
      req0_op    = 4'($urandom_range(0, 15));
      req0_x     = $urandom;
      req0_y     = $urandom;
      req0_shamt = 5'($urandom_range(0, 31));
    end
    if (!hold1) begin
      req1_valid = ($urandom_range(0, 99) < 65);
      req1_op    = 4'($urandom_range(0, 15));
      req1_x     = $urandom;
      req1_y     = $urandom;
      req1_shamt = 5'($urandom_range(0, 31));
    end
    res_ready = ($urandom_range(0, 99) < 60);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  sh;
    logic [31:0] exp;
  } opCase_t;

  initial begin
    opCase_t opTable[5];
    opTable[0] = '{OP_SRA,  32'h0,          32'h8000_0000, 5'd4, 32'hF800_0000};
    opTable[1] = '{OP_SLT,  32'hFFFF_FFFF,  32'h1,         5'd0, 32'h1};
    opTable[2] = '{OP_SLTU, 32'hFFFF_FFFF,  32'h1,         5'd0, 32'h0};
    opTable[3] = '{OP_LUI,  32'h0,          32'h1234,      5'd0, 32'h1234_0000};
    opTable[4] = '{4'd15,   32'h5,          32'h7,         5'd3, 32'h0};

    // reset state with both requesters asking
    rst = 1'b1;
    drive0(1'b1, OP_ADD, 32'd1, 32'd1, 5'd0);
    drive1(1'b1, OP_ADD, 32'd2, 32'd2, 5'd0);
    res_ready = 1'b0;
    q0_valid = 1'b1; q0_op = OP_SUB; q0_x = 32'd10; q0_y = 32'd3; q0_shamt = 5'd0;
    q1_valid = 1'b1; q1_op = OP_OR;  q1_x = 32'hF0; q1_y = 32'h0F; q1_shamt = 5'd0;
    qRes_ready = 1'b0;
    modelReset();
    @(negedge clk);
    #1;
    checkOutput("rst_req0_ready", req0_ready, 0);
    checkOutput("rst_req1_ready", req1_ready, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res_data", res_data, 0);
    checkOutput("rst_res_src", res_src, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_prio_req0_ready", q0_ready, 0);
    checkOutput("rst_prio_res_valid", qRes_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    q0_valid = 1'b0; q1_valid = 1'b0;

    // single request accepted on the first edge after reset
    drive0(1'b1, OP_ADD, 32'd5, 32'd7, 5'd0);
    drive1(1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
    res_ready = 1'b1;
    #1 checkOutput("single_ready", req0_ready, 1);
    stepCycle();
    checkOutput("single_valid", res_valid, 1);
    checkOutput("single_data", res_data, 32'd12);
    checkOutput("single_src", res_src, 0);

    // requester drops valid: no second result
    drive0(1'b0, OP_ADD, 32'd5, 32'd7, 5'd0);
    stepCycle();
    checkOutput("no_dup_valid", res_valid, 0);

    // lone requester wins whatever the pointer says
    drive0(1'b1, OP_XOR, 32'h0F0F, 32'h00FF, 5'd0);
    stepCycle();
    drive0(1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
    drive1(1'b1, OP_SLL, 32'd0, 32'd3, 5'd2);
    stepCycle();
    checkOutput("lone1_data", res_data, 32'd12);
    checkOutput("lone1_src", res_src, 1);

    // round-robin contention: grants 0,1,0 with back-to-back results
    drive0(1'b1, OP_SUB, 32'd10, 32'd3, 5'd0);
    drive1(1'b1, OP_OR, 32'hF0, 32'h0F, 5'd0);
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("rr_grant0", req0_ready, (i != 1));
      checkOutput("rr_grant1", req1_ready, (i == 1));
      stepCycle();
      checkOutput("rr_data", res_data, (i == 1) ? 32'hFF : 32'd7);
      checkOutput("rr_valid", res_valid, 1);
    end
    drive0(1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
    stepCycle();

    // backpressure: 0x10 held while requester 1 waits
    drive1(1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
    drive0(1'b1, OP_ADD, 32'h8, 32'h8, 5'd0);
    stepCycle();
    drive0(1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
    drive1(1'b1, OP_ADD, 32'd1, 32'd2, 5'd0);
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 checkOutput("bp_ready", req1_ready, 0);
      checkOutput("bp_busy", busy, 1);
      stepCycle();
      checkOutput("bp_hold", res_data, 32'h10);
    end
    res_ready = 1'b1;
    #1 checkOutput("bp_release_ready", req1_ready, 1);
    stepCycle();
    checkOutput("bp_new_data", res_data, 32'd3);
    checkOutput("bp_new_src", res_src, 1);
    drive1(1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
    stepCycle();

    // shift, signed compare, LUI and undefined op
    foreach (opTable[i]) begin
      drive0(1'b1, opTable[i].op, opTable[i].x, opTable[i].y, opTable[i].sh);
      stepCycle();
      checkOutput("op_table", res_data, opTable[i].exp);
    end
    drive0(1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
    stepCycle();

    // fixed-priority instance: port 0 always wins contention
    qRes_ready = 1'b1;
    q0_valid = 1'b0; q1_valid = 1'b1;
    prioCycle(1'b0, 1'b1, 32'hFF, 1'b1);
    q0_valid = 1'b1; q1_valid = 1'b0;
    prioCycle(1'b1, 1'b0, 32'd7, 1'b0);
    q1_valid = 1'b1;
    for (int i = 0; i < 3; i++) prioCycle(1'b1, 1'b0, 32'd7, 1'b0);
    q0_valid = 1'b0; q1_valid = 1'b0;

    // asynchronous reset with a pending result
    drive0(1'b1, OP_ADD, 32'd20, 32'd22, 5'd0);
    res_ready = 1'b0;
    stepCycle();
    checkOutput("pre_rst_valid", res_valid, 1);
    drive0(1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", res_valid, 0);
    checkOutput("async_rst_data", res_data, 0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
    stepCycle();
    checkOutput("post_rst_no_result", res_valid, 0);
    drive0(1'b1, OP_ADD, 32'd1, 32'd2, 5'd0);
    drive1(1'b1, OP_AND, 32'hFF, 32'h0F, 5'd0);
    #1 checkOutput("post_rst_grant0", req0_ready, 1);
    checkOutput("post_rst_grant1", req1_ready, 0);
    stepCycle();

    // randomized run against the model
    for (int n = 0; n < 500; n++) begin
      applyStimulus();
      stepCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
